// File: rtl/sobel_window_sequencer.sv
// Walks image memory and delivers 3x3 windows to sobel_core: full prime per row, one new column per step.
// Optional SOBEL_SEQ_BORDER_EN: windows for every pixel, out-of-range taps zero.
module sobel_window_sequencer #(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_W     = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    mem_rd_en,
  output logic [ADDR_W-1:0]       mem_row,
  output logic [ADDR_W-1:0]       mem_col,
  input  logic [DATA_WIDTH-1:0]   mem_pixel,
  output logic [9*DATA_WIDTH-1:0] win_flat,
  output logic                    win_valid,
  input  logic                    win_ready,
  output logic [ADDR_W-1:0]       win_row,
  output logic [ADDR_W-1:0]       win_col
);

`ifdef SOBEL_SEQ_BORDER_EN
  localparam int FIRST  = 0;
  localparam int LAST_C = IMG_WIDTH - 1;
  localparam int LAST_R = IMG_HEIGHT - 1;
`else
  localparam int FIRST  = 1;
  localparam int LAST_C = IMG_WIDTH - 2;
  localparam int LAST_R = IMG_HEIGHT - 2;
`endif

  localparam logic [ADDR_W:0] FIRST_V  = (ADDR_W+1)'(FIRST);
  localparam logic [ADDR_W:0] LAST_C_V = (ADDR_W+1)'(LAST_C);
  localparam logic [ADDR_W:0] LAST_R_V = (ADDR_W+1)'(LAST_R);

  typedef enum logic [2:0] {IDLE, PRIME, FETCH, PRESENT, DONE} state_t;

  state_t                state;
  logic [ADDR_W:0]       row;
  logic [ADDR_W:0]       col;
  logic [3:0]            cnt;
  logic                  rd_q;
  logic [DATA_WIDTH-1:0] win [3][3];
  logic [DATA_WIDTH-1:0] pix;
  logic [1:0]            cap_i;
  logic [3:0]            last_slot;

  // Slot s reads row offset s%3 of column (centre-1 for prime, centre+1 for fetch) + s/3;
  // out-of-range taps return a cleared strobe so the slot is spent without a read.
  function automatic logic [2*ADDR_W:0] issue_addr(input logic prime, input logic [ADDR_W:0] r,
                                                   input logic [ADDR_W:0] c, input logic [3:0] s);
    int tr;
    int tc;
    tr = int'(r) - 1 + int'(s) % 3;
    tc = int'(c) + (prime ? -1 : 1) + int'(s) / 3;
    if (tr >= 0 && tr < IMG_HEIGHT && tc >= 0 && tc < IMG_WIDTH)
      issue_addr = {1'b1, tr[ADDR_W-1:0], tc[ADDR_W-1:0]};
    else
      issue_addr = '0;
  endfunction

  always_comb begin
    pix       = rd_q ? mem_pixel : '0;
    cap_i     = 2'((cnt - 4'd1) % 4'd3);
    last_slot = (state == PRIME) ? 4'd9 : 4'd3;
  end

  for (genvar i = 0; i < 3; i++) begin : g_row
    for (genvar j = 0; j < 3; j++) begin : g_col
      assign win_flat[(3*i+j)*DATA_WIDTH +: DATA_WIDTH] = win[i][j];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_row   <= '0;
      mem_col   <= '0;
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
      row       <= '0;
      col       <= '0;
      cnt       <= '0;
      rd_q      <= 1'b0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          win[i][j] <= '0;
    end else begin
      rd_q <= mem_rd_en;
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= PRIME;
            busy  <= 1'b1;
            row   <= FIRST_V;
            col   <= FIRST_V;
            cnt   <= 4'd0;
            {mem_rd_en, mem_row, mem_col} <= issue_addr(1'b1, FIRST_V, FIRST_V, 4'd0);
          end
        end
        PRIME, FETCH: begin
          // Each landing pixel enters its row at j=2 and pushes that row left.
          if (cnt != 4'd0) begin
            win[cap_i][0] <= win[cap_i][1];
            win[cap_i][1] <= win[cap_i][2];
            win[cap_i][2] <= pix;
          end
          if (cnt == last_slot) begin
            state     <= PRESENT;
            win_valid <= 1'b1;
            win_row   <= row[ADDR_W-1:0];
            win_col   <= col[ADDR_W-1:0];
          end else begin
            cnt <= cnt + 4'd1;
            if (cnt + 4'd1 < last_slot)
              {mem_rd_en, mem_row, mem_col} <= issue_addr(state == PRIME, row, col, cnt + 4'd1);
            else
              mem_rd_en <= 1'b0;
          end
        end
        PRESENT: begin
          if (win_ready) begin
            win_valid <= 1'b0;
            cnt       <= 4'd0;
            if (col < LAST_C_V) begin
              col   <= col + 1'b1;
              state <= FETCH;
              {mem_rd_en, mem_row, mem_col} <= issue_addr(1'b0, row, col + 1'b1, 4'd0);
            end else if (row < LAST_R_V) begin
              row   <= row + 1'b1;
              col   <= FIRST_V;
              state <= PRIME;
              {mem_rd_en, mem_row, mem_col} <= issue_addr(1'b1, row + 1'b1, FIRST_V, 4'd0);
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sobel_window_sequencer.md
Name: sobel_window_sequencer

Overview:
Controller that walks a synchronous image memory and delivers 3x3 pixel windows to the sobel_core datapath.
- Primes the full window once at the start of each output row.
- For each later column, fetches only the new right-hand column (3 reads) and shifts the window left.
- Presents each window with a valid/ready handshake, so downstream gradient/output logic can apply backpressure.
- Replaces per-pixel 9-read window assembly in the top-level Sobel flow.

Parameters:
IMG_WIDTH, 8, image columns (>=3)
IMG_HEIGHT, 8, image rows (>=3)
DATA_WIDTH, 8, pixel width
ADDR_W, 3, width of mem_row/mem_col and win_row/win_col (2**ADDR_W >= max(IMG_WIDTH, IMG_HEIGHT))

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  begin a frame; sampled only in IDLE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last window handshake
mem_rd_en  out  1  read strobe to image memory
mem_row  out  ADDR_W  read row address
mem_col  out  ADDR_W  read column address
mem_pixel  in  DATA_WIDTH  read data, valid exactly 1 cycle after mem_rd_en
win_flat  out  9*DATA_WIDTH  window; tap [i][j] at bits (3*i+j)*DATA_WIDTH +: DATA_WIDTH, i=row offset 0..2 (top..bottom), j=col offset 0..2 (left..right)
win_valid  out  1  window valid
win_ready  in  1  downstream accepts window
win_row  out  ADDR_W  centre row of presented window
win_col  out  ADDR_W  centre column of presented window

Behaviour:
- Reset (rst=1 at a clock edge, any state including mid-frame):
  - Next state IDLE.
  - busy, done, mem_rd_en, win_valid all 0.
  - mem_row, mem_col, win_row, win_col 0; win_flat all 0.
  - Any in-flight read is discarded.
- States: IDLE, PRIME, FETCH, PRESENT, DONE.
- IDLE:
  - start=1 -> centre (row,col)=(1,1), go to PRIME.
  - start in any other state is ignored.
- Memory reads:
  - Column-major, top to bottom: (row-1,c), (row,c), (row+1,c).
  - One read issued per cycle; the data is captured on the following edge.
- PRIME:
  - 9 issue cycles for columns col-1, col, col+1, plus 1 drain cycle = 10 cycles.
  - Then go to PRESENT.
- FETCH:
  - 3 issue cycles for column col+1, plus 1 drain cycle = 4 cycles.
  - The window shifts left by one column as the new column lands in j=2.
  - Then go to PRESENT.
- PRESENT:
  - win_valid=1; win_flat, win_row, win_col held stable while win_ready=0.
  - mem_rd_en=0 throughout.
  - On win_valid & win_ready:
    - If col < IMG_WIDTH-2: col+1, go to FETCH.
    - Else if row < IMG_HEIGHT-2: row+1, col=1, go to PRIME.
    - Else: go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. start is ignored during DONE.
- Frame totals:
  - (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows.
  - With win_ready tied high, cycles per row = 11 + 5*(IMG_WIDTH-3).
  - 8x8 frame: 216 cycles from PRIME entry to DONE.
- Counters are ADDR_W+1 bits internally; address arithmetic never wraps for legal parameters.

Optional Feature:
Macro: SOBEL_SEQ_BORDER_EN
- Defined:
  - Emits windows for every pixel, centres (0..IMG_HEIGHT-1, 0..IMG_WIDTH-1), IMG_WIDTH*IMG_HEIGHT windows.
  - Out-of-range taps are zero.
  - The cycle slot for an out-of-range tap is still consumed (10/4-cycle PRIME/FETCH timing unchanged), with mem_rd_en=0 in that slot.
- Undefined: interior windows only, as above.

Test Plan:
1. 8x8 memory with pixel=row*8+col, win_ready=1, start pulse ->
   - first win_valid 10 cycles after PRIME entry, window (1,1) = {0,1,2,8,9,10,16,17,18};
   - 36 windows, last at (6,6) = {45,46,47,53,54,55,61,62,63};
   - done pulse 1 cycle after last handshake; 216 cycles PRIME-entry to DONE.
2. Backpressure: win_ready=0 for 5 cycles on window (2,3) -> win_flat/win_row/win_col constant, mem_rd_en=0, no window lost or duplicated; sequence matches scenario 1.
3. start asserted while busy=1 -> ignored, window count still 36, single done pulse.
4. rst=1 for one cycle during FETCH of row 3 -> next cycle IDLE with all outputs zero; a fresh start produces a correct frame from (1,1).
5. SOBEL_SEQ_BORDER_EN defined, same image ->
   - 64 windows; (0,0) window = {0,0,0,0,0,1,0,8,9};
   - no mem_rd_en with row or col outside 0..7.
